// File: rtl/generic_sc_upsize_fifo.sv
// Single-clock width-widening FIFO: narrow words in, packed wide words out (first word in LSBs).
// Optional show-ahead read port selected by defining UPSIZE_FIFO_SHOWAHEAD_EN.
module generic_sc_upsize_fifo #(
  parameter int RD_ADDR_W = 5,
  parameter int WR_DATA_W = 16,
  parameter int RD_DATA_W = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               wr_en_i,
  input  logic [WR_DATA_W-1:0]               wr_data_i,
  output logic [RD_ADDR_W+$clog2(RD_DATA_W/WR_DATA_W):0] wr_usedw_o,
  output logic                               wr_empty_o,
  output logic                               wr_full_o,
  input  logic                               rd_en_i,
  output logic [RD_DATA_W-1:0]               rd_data_o,
  output logic [RD_ADDR_W:0]                 rd_usedw_o,
  output logic                               rd_empty_o,
  output logic                               rd_full_o
);

  localparam int DATA_RATIO = RD_DATA_W / WR_DATA_W;
  localparam int EXTEND_W   = $clog2(DATA_RATIO);
  localparam int WR_ADDR_W  = RD_ADDR_W + EXTEND_W;
  localparam int CNT_W      = WR_ADDR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(2 ** WR_ADDR_W);
  localparam logic [CNT_W-1:0] CNT_RATIO = CNT_W'(DATA_RATIO);

  logic [RD_DATA_W-1:0] mem_q [2**RD_ADDR_W];

  logic [WR_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [RD_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 wr_full, rd_empty;
  logic                 wr_accept, rd_accept;
  logic [EXTEND_W-1:0]  wr_lane;
  logic [RD_ADDR_W-1:0] wr_row;

  // Flags come only from the registered count, never from the enables.
  assign wr_full   = (cnt_q == CNT_FULL);
  assign rd_empty  = (cnt_q < CNT_RATIO);
  assign wr_accept = wr_en_i && !wr_full;
  assign rd_accept = rd_en_i && !rd_empty;

  assign wr_lane = wr_ptr_q[EXTEND_W-1:0];
  assign wr_row  = wr_ptr_q[WR_ADDR_W-1:EXTEND_W];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    // One count in narrow units; a wide read removes DATA_RATIO of them.
    case ({wr_accept, rd_accept})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - CNT_RATIO;
      2'b11:   cnt_d = cnt_q + 1'b1 - CNT_RATIO;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: the storage array has no reset; the count alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_accept) mem_q[wr_row][int'(wr_lane)*WR_DATA_W +: WR_DATA_W] <= wr_data_i;
  end

`ifdef UPSIZE_FIFO_SHOWAHEAD_EN
  // Head row is presented straight from storage; a pop advances rd_ptr to the next row.
  assign rd_data_o = mem_q[rd_ptr_q];
`else
  logic [RD_DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_accept) rd_data_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;
`endif

  assign wr_usedw_o = cnt_q;
  assign wr_empty_o = (cnt_q == '0);
  assign wr_full_o  = wr_full;
  assign rd_usedw_o = cnt_q[CNT_W-1:EXTEND_W];
  assign rd_empty_o = rd_empty;
  assign rd_full_o  = wr_full;

endmodule

// File: tb/tb_generic_sc_upsize_fifo.sv
// Self-checking bench for generic_sc_upsize_fifo (default parameters), against a queue model
// of narrow words. Honours UPSIZE_FIFO_SHOWAHEAD_EN for the read-data sampling point.
module tb_generic_sc_upsize_fifo;

  localparam int DEPTH_N = 64;   // narrow-word capacity

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [15:0] wr_data_i = '0;
  logic        rd_en_i = 1'b0;
  logic [6:0]  wr_usedw_o;
  logic        wr_empty_o, wr_full_o;
  logic [31:0] rd_data_o;
  logic [5:0]  rd_usedw_o;
  logic        rd_empty_o, rd_full_o;

  generic_sc_upsize_fifo dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .wr_usedw_o (wr_usedw_o),
    .wr_empty_o (wr_empty_o),
    .wr_full_o  (wr_full_o),
    .rd_en_i    (rd_en_i),
    .rd_data_o  (rd_data_o),
    .rd_usedw_o (rd_usedw_o),
    .rd_empty_o (rd_empty_o),
    .rd_full_o  (rd_full_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: ordered narrow words currently stored.
  logic [15:0] nq[$];
  logic [31:0] exp_rd;      // word the last accepted read should return
  logic [31:0] got_rd;      // observed read data for the last cycle
  logic        rd_taken;    // model says last cycle's read was accepted

  function automatic logic [16:0] exp_status();
    int sz;
    sz = nq.size();
    return {7'(sz), 6'(sz / 2), sz == 0, sz == DEPTH_N, sz < 2, sz == DEPTH_N};
  endfunction

  function automatic logic [16:0] dut_status();
    return {wr_usedw_o, rd_usedw_o, wr_empty_o, wr_full_o, rd_empty_o, rd_full_o};
  endfunction

  // One clock cycle of stimulus; model acceptance uses pre-edge occupancy.
  task automatic cycle(input logic we, input logic [15:0] wd, input logic re);
    logic w_ok, r_ok;
    wr_en_i   = we;
    wr_data_i = wd;
    rd_en_i   = re;
    w_ok = we && (nq.size() < DEPTH_N);
    r_ok = re && (nq.size() >= 2);
    rd_taken = r_ok;
`ifdef UPSIZE_FIFO_SHOWAHEAD_EN
    got_rd = rd_data_o;
`endif
    if (r_ok) begin
      exp_rd = {nq[1], nq[0]};
      void'(nq.pop_front());
      void'(nq.pop_front());
    end
    if (w_ok) nq.push_back(wd);
    @(posedge clk_i);
    #1;
`ifndef UPSIZE_FIFO_SHOWAHEAD_EN
    got_rd = rd_data_o;
`endif
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  task automatic do_reset();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    rst_i   = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    nq.delete();
    exp_rd = '0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_status() !== 17'b0000000_000000_1_0_1_0) begin
      n_errors++;
      $display("FAIL reset_status: got %h expected %h", dut_status(), 17'b0000000_000000_1_0_1_0);
    end
`ifndef UPSIZE_FIFO_SHOWAHEAD_EN
    n_checks++;
    if (rd_data_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_rd_data: got %h expected %h", rd_data_o, 32'h0);
    end
`endif
  endtask

  task automatic test_basic_pair();
    cycle(1'b1, 16'h1111, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0);
    n_checks++;
    if (dut_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL pair_status: got %h expected %h", dut_status(), exp_status());
    end
    cycle(1'b0, 16'h0, 1'b1);
    n_checks++;
    if (got_rd !== 32'h22221111) begin
      n_errors++;
      $display("FAIL pair_data: got %h expected %h", got_rd, 32'h22221111);
    end
    n_checks++;
    if (dut_status() !== exp_status() || !wr_empty_o || !rd_empty_o) begin
      n_errors++;
      $display("FAIL pair_empty: got %h expected %h", dut_status(), exp_status());
    end
  endtask

  task automatic test_partial_word();
    cycle(1'b1, 16'hAAAA, 1'b0);
    n_checks++;
    if (dut_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL partial_status: got %h expected %h", dut_status(), exp_status());
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 1'b1);
      n_checks++;
      if (dut_status() !== exp_status() || rd_taken) begin
        n_errors++;
        $display("FAIL partial_ignored_read%0d: got %h expected %h", i, dut_status(), exp_status());
      end
`ifndef UPSIZE_FIFO_SHOWAHEAD_EN
      n_checks++;
      if (rd_data_o !== 32'h22221111) begin
        n_errors++;
        $display("FAIL partial_hold%0d: got %h expected %h", i, rd_data_o, 32'h22221111);
      end
`endif
    end
    cycle(1'b1, 16'hBBBB, 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    n_checks++;
    if (got_rd !== 32'hBBBBAAAA) begin
      n_errors++;
      $display("FAIL partial_data: got %h expected %h", got_rd, 32'hBBBBAAAA);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int round = 0; round < 3; round++) begin
      // Later rounds start misaligned so the pointers wrap mid-memory.
      if (round > 0) begin
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0);
        cycle(1'b0, 16'h0, 1'b1);
      end
      for (int i = 0; i < DEPTH_N && nq.size() < DEPTH_N; i++) cycle(1'b1, 16'($urandom), 1'b0);
      n_checks++;
      if (dut_status() !== exp_status() || !wr_full_o || !rd_full_o || rd_usedw_o !== 6'd32) begin
        n_errors++;
        $display("FAIL fill_full%0d: got %h expected %h", round, dut_status(), exp_status());
      end
      cycle(1'b1, 16'($urandom), 1'b0);
      n_checks++;
      if (dut_status() !== exp_status() || wr_usedw_o !== 7'd64) begin
        n_errors++;
        $display("FAIL fill_overflow%0d: got %h expected %h", round, dut_status(), exp_status());
      end
      for (int i = 0; i < 32; i++) begin
        cycle(1'b0, 16'h0, 1'b1);
        n_checks++;
        if (got_rd !== exp_rd || dut_status() !== exp_status()) begin
          n_errors++;
          $display("FAIL drain%0d_%0d: got %h/%h expected %h/%h",
                   round, i, got_rd, dut_status(), exp_rd, exp_status());
        end
      end
    end
  endtask

  task automatic test_full_simultaneous();
    for (int i = 0; i < DEPTH_N && nq.size() < DEPTH_N; i++) cycle(1'b1, 16'($urandom), 1'b0);
    cycle(1'b1, 16'($urandom), 1'b1);
    n_checks++;
    if (got_rd !== exp_rd || wr_usedw_o !== 7'd62 || dut_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL full_both_1: got %h/%0d expected %h/62", got_rd, wr_usedw_o, exp_rd);
    end
    cycle(1'b1, 16'($urandom), 1'b1);
    n_checks++;
    if (got_rd !== exp_rd || wr_usedw_o !== 7'd61 || dut_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL full_both_2: got %h/%0d expected %h/61", got_rd, wr_usedw_o, exp_rd);
    end
    for (int i = 0; i < 40 && nq.size() >= 2; i++) begin
      cycle(1'b0, 16'h0, 1'b1);
      n_checks++;
      if (got_rd !== exp_rd || dut_status() !== exp_status()) begin
        n_errors++;
        $display("FAIL full_drain%0d: got %h expected %h", i, got_rd, exp_rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 20 && !rd_empty_o; i++) begin
      prev = int'(wr_usedw_o);
      cycle(1'b1, 16'($urandom), 1'b1);
      n_checks++;
      if (got_rd !== exp_rd || dut_status() !== exp_status() || int'(wr_usedw_o) != prev - 1) begin
        n_errors++;
        $display("FAIL steady%0d: got %h/%0d expected %h/%0d", i, got_rd, wr_usedw_o, exp_rd, prev - 1);
      end
    end
    n_checks++;
    if (!rd_empty_o || wr_usedw_o !== 7'd1) begin
      n_errors++;
      $display("FAIL steady_end: got empty=%b used=%0d expected empty=1 used=1", rd_empty_o, wr_usedw_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'($urandom), 1'b0);
    n_checks++;
    if (dut_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL async_pre: got %h expected %h", dut_status(), exp_status());
    end
    wr_en_i   = 1'b1;
    wr_data_i = 16'h5A5A;
    #3;
    rst_i = 1'b1;
    nq.delete();
    #1;
    n_checks++;
    if (dut_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL async_immediate: got %h expected %h", dut_status(), exp_status());
    end
`ifndef UPSIZE_FIFO_SHOWAHEAD_EN
    n_checks++;
    if (rd_data_o !== 32'h0) begin
      n_errors++;
      $display("FAIL async_rd_data: got %h expected %h", rd_data_o, 32'h0);
    end
`endif
    wr_en_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    cycle(1'b1, 16'h0001, 1'b0);
    cycle(1'b1, 16'h0002, 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    n_checks++;
    if (got_rd !== 32'h00020001 || dut_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL async_after: got %h expected %h", got_rd, 32'h00020001);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_rd   = '0;
    got_rd   = '0;
    rd_taken = 1'b0;
    test_reset();
    test_basic_pair();
    test_partial_word();
    test_fill_drain();
    test_full_simultaneous();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
